// File: rtl/czonotope_loader_if.sv
// rtl/czonotope_loader_if.sv - constrained-zonotope bundle (n/ng/nc, c, G, A, b)
// Ports (signals):
//   n, ng, nc : 8-bit dimension, generator count, constraint count
//   c[NMAX]            : centre vector
//   g[NMAX][NGMAX]     : generator matrix, row i, column j
//   a[NCMAX][NGMAX]    : constraint matrix, row i, column j
//   b[NCMAX]           : constraint right-hand side
//   master : driven by the loader; slave : read by downstream ops
interface czonotope_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NMAX       = 2,
    parameter int NGMAX      = 5,
    parameter int NCMAX      = 3
) ();
    logic [7:0]            n;
    logic [7:0]            ng;
    logic [7:0]            nc;
    logic [DATA_WIDTH-1:0] c [NMAX];
    logic [DATA_WIDTH-1:0] g [NMAX][NGMAX];
    logic [DATA_WIDTH-1:0] a [NCMAX][NGMAX];
    logic [DATA_WIDTH-1:0] b [NCMAX];

    modport master (output n, ng, nc, c, g, a, b);
    modport slave  (input  n, ng, nc, c, g, a, b);
endinterface

// File: rtl/czonotope_loader.sv
// rtl/czonotope_loader.sv - unpacks a word stream into a held constrained zonotope
// Ports:
//   clk_i, rstn_i       : clock, synchronous active-low reset
//   s_data_i/s_valid_i  : input stream word and its valid
//   s_ready_o           : loader accepts a word this cycle
//   Z                   : loaded zonotope (master side of czonotope_loader_if)
//   z_valid_o           : Z complete and stable
//   done_o / err_o      : one-cycle pulses for load complete / header rejected
// Stream order: header {nc[23:16], ng[15:8], n[7:0]}, then c, G row-major, A row-major, b.
module czonotope_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int NMAX       = 2,
    parameter int NGMAX      = 5,
    parameter int NCMAX      = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    czonotope_loader_if.master    Z,
    output logic                  z_valid_o,
    output logic                  done_o,
    output logic                  err_o
);
    typedef enum logic [2:0] {S_IDLE, S_C, S_G, S_A, S_B, S_DONE, S_ERR} state_t;

    state_t     state_q;
    logic [7:0] row_q;
    logic [7:0] col_q;
    logic [7:0] col_lim;
    logic [7:0] row_lim;
    logic       accept;
    logic       col_last;
    logic       row_last;
    logic       hdr_ok;
    logic       clear_all;
    logic [7:0] hdr_n;
    logic [7:0] hdr_ng;
    logic [7:0] hdr_nc;

    assign accept = s_valid_i && s_ready_o;
    assign hdr_n  = s_data_i[7:0];
    assign hdr_ng = s_data_i[15:8];
    assign hdr_nc = s_data_i[23:16];
    assign hdr_ok = (hdr_n  >= 8'd1) && (hdr_n  <= 8'(NMAX))  &&
                    (hdr_ng >= 8'd1) && (hdr_ng <= 8'(NGMAX)) &&
                    (hdr_nc <= 8'(NCMAX));

    // C and B are single rows, so only the column counter walks them.
    always_comb begin
        col_lim = 8'd0;
        case (state_q)
            S_C:      col_lim = Z.n;
            S_G, S_A: col_lim = Z.ng;
            S_B:      col_lim = Z.nc;
            default:  col_lim = 8'd0;
        endcase
    end

    assign row_lim  = (state_q == S_G) ? Z.n : Z.nc;
    assign col_last = (col_q == col_lim - 8'd1);
    assign row_last = (row_q == row_lim - 8'd1);

    // A fresh load starts from an all-zero zonotope so unused entries never hold stale data.
    assign clear_all = !rstn_i || (state_q == S_IDLE && accept && hdr_ok);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
            s_ready_o <= 1'b1;
            z_valid_o <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            Z.n       <= 8'd0;
            Z.ng      <= 8'd0;
            Z.nc      <= 8'd0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            Z.n       <= hdr_n;
                            Z.ng      <= hdr_ng;
                            Z.nc      <= hdr_nc;
                            z_valid_o <= 1'b0;
                            row_q     <= 8'd0;
                            col_q     <= 8'd0;
                            state_q   <= S_C;
                        end else begin
                            err_o     <= 1'b1;
                            s_ready_o <= 1'b0;
                            state_q   <= S_ERR;
                        end
                    end
                end
                S_C: begin
                    if (accept) begin
                        for (int k = 0; k < NMAX; k++)
                            if (8'(k) == col_q) Z.c[k] <= s_data_i;
                        if (col_last) begin
                            col_q   <= 8'd0;
                            state_q <= S_G;
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                S_G: begin
                    if (accept) begin
                        for (int i = 0; i < NMAX; i++)
                            for (int j = 0; j < NGMAX; j++)
                                if (8'(i) == row_q && 8'(j) == col_q) Z.g[i][j] <= s_data_i;
                        if (col_last) begin
                            col_q <= 8'd0;
                            if (row_last) begin
                                row_q <= 8'd0;
                                if (Z.nc == 8'd0) begin
                                    done_o    <= 1'b1;
                                    z_valid_o <= 1'b1;
                                    s_ready_o <= 1'b0;
                                    state_q   <= S_DONE;
                                end else begin
                                    state_q <= S_A;
                                end
                            end else begin
                                row_q <= row_q + 8'd1;
                            end
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                S_A: begin
                    if (accept) begin
                        for (int i = 0; i < NCMAX; i++)
                            for (int j = 0; j < NGMAX; j++)
                                if (8'(i) == row_q && 8'(j) == col_q) Z.a[i][j] <= s_data_i;
                        if (col_last) begin
                            col_q <= 8'd0;
                            if (row_last) begin
                                row_q   <= 8'd0;
                                state_q <= S_B;
                            end else begin
                                row_q <= row_q + 8'd1;
                            end
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                S_B: begin
                    if (accept) begin
                        for (int k = 0; k < NCMAX; k++)
                            if (8'(k) == col_q) Z.b[k] <= s_data_i;
                        if (col_last) begin
                            col_q     <= 8'd0;
                            done_o    <= 1'b1;
                            z_valid_o <= 1'b1;
                            s_ready_o <= 1'b0;
                            state_q   <= S_DONE;
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                default: begin
                    // DONE and ERR each hold ready low for exactly one cycle.
                    s_ready_o <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end

        if (clear_all) begin
            for (int i = 0; i < NMAX; i++) begin
                Z.c[i] <= '0;
                for (int j = 0; j < NGMAX; j++) Z.g[i][j] <= '0;
            end
            for (int i = 0; i < NCMAX; i++) begin
                Z.b[i] <= '0;
                for (int j = 0; j < NGMAX; j++) Z.a[i][j] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_czonotope_loader.sv
// tb/tb_czonotope_loader.sv - bench for czonotope_loader: load model, per-cycle compare, directed loads
module tb_czonotope_loader;
    localparam int DW    = 32;
    localparam int NMAX  = 2;
    localparam int NGMAX = 5;
    localparam int NCMAX = 3;

    logic          clk_tb = 1'b0;
    logic          rstn;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          z_valid;
    logic          done;
    logic          err;

    always #5 clk_tb = ~clk_tb;

    czonotope_loader_if #(.DATA_WIDTH(DW), .NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX)) zif ();

    czonotope_loader #(.DATA_WIDTH(DW), .NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX)) dut (
        .clk_i     (clk_tb),
        .rstn_i    (rstn),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .Z         (zif),
        .z_valid_o (z_valid),
        .done_o    (done),
        .err_o     (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_tb) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: a load is a list of payload words; once all 1+n+n*ng+nc*ng+nc words are in,
    // the zonotope is rebuilt from the list by position.
    bit            m_live = 1'b0;
    bit            m_ready, m_zvalid, m_done, m_err, m_cool;
    int            m_n, m_ng, m_nc, m_remain;
    logic [DW-1:0] m_c [NMAX];
    logic [DW-1:0] m_g [NMAX][NGMAX];
    logic [DW-1:0] m_a [NCMAX][NGMAX];
    logic [DW-1:0] m_b [NCMAX];
    logic [DW-1:0] m_words [$];

    task automatic model_clear();
        for (int i = 0; i < NMAX; i++) begin
            m_c[i] = '0;
            for (int j = 0; j < NGMAX; j++) m_g[i][j] = '0;
        end
        for (int i = 0; i < NCMAX; i++) begin
            m_b[i] = '0;
            for (int j = 0; j < NGMAX; j++) m_a[i][j] = '0;
        end
    endtask

    task automatic model_fill();
        int base;
        for (int i = 0; i < m_n; i++) m_c[i] = m_words[i];
        base = m_n;
        for (int i = 0; i < m_n; i++)
            for (int j = 0; j < m_ng; j++) m_g[i][j] = m_words[base + i*m_ng + j];
        base = base + m_n*m_ng;
        for (int i = 0; i < m_nc; i++)
            for (int j = 0; j < m_ng; j++) m_a[i][j] = m_words[base + i*m_ng + j];
        base = base + m_nc*m_ng;
        for (int i = 0; i < m_nc; i++) m_b[i] = m_words[base + i];
    endtask

    initial forever begin
        int hn, hng, hnc;
        @(posedge clk_tb);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rstn) begin
            m_live = 1'b1; m_ready = 1'b1; m_zvalid = 1'b0; m_cool = 1'b0;
            m_n = 0; m_ng = 0; m_nc = 0; m_remain = 0;
            model_clear();
        end else if (m_live && m_cool) begin
            m_cool  = 1'b0;
            m_ready = 1'b1;
        end else if (m_live && s_valid && m_ready) begin
            if (m_remain == 0) begin
                hn  = int'(s_data[7:0]);
                hng = int'(s_data[15:8]);
                hnc = int'(s_data[23:16]);
                if (hn >= 1 && hn <= NMAX && hng >= 1 && hng <= NGMAX && hnc <= NCMAX) begin
                    m_n = hn; m_ng = hng; m_nc = hnc;
                    m_remain = hn + hn*hng + hnc*hng + hnc;
                    m_zvalid = 1'b0;
                    m_words.delete();
                    model_clear();
                end else begin
                    m_err = 1'b1; m_ready = 1'b0; m_cool = 1'b1;
                end
            end else begin
                m_words.push_back(s_data);
                m_remain--;
                if (m_remain == 0) begin
                    model_fill();
                    m_done = 1'b1; m_zvalid = 1'b1; m_ready = 1'b0; m_cool = 1'b1;
                end
            end
        end
    end

    // Compare every cycle; array contents are only meaningful once a load is complete
    // or when the zonotope is known empty (after reset).
    initial forever begin
        @(negedge clk_tb);
        if (m_live) begin
            chk("s_ready", 32'(s_ready), 32'(m_ready));
            chk("z_valid", 32'(z_valid), 32'(m_zvalid));
            chk("done",    32'(done),    32'(m_done));
            chk("err",     32'(err),     32'(m_err));
            chk("n",  32'(zif.n),  32'(m_n));
            chk("ng", 32'(zif.ng), 32'(m_ng));
            chk("nc", 32'(zif.nc), 32'(m_nc));
            if (m_zvalid || m_n == 0) begin
                for (int i = 0; i < NMAX; i++) begin
                    chk($sformatf("c[%0d]", i), zif.c[i], m_c[i]);
                    for (int j = 0; j < NGMAX; j++)
                        chk($sformatf("g[%0d][%0d]", i, j), zif.g[i][j], m_g[i][j]);
                end
                for (int i = 0; i < NCMAX; i++) begin
                    chk($sformatf("b[%0d]", i), zif.b[i], m_b[i]);
                    for (int j = 0; j < NGMAX; j++)
                        chk($sformatf("a[%0d][%0d]", i, j), zif.a[i][j], m_a[i][j]);
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, output int acc);
        int k;
        s_data  = d;
        s_valid = 1'b1;
        k       = 0;
        acc     = -1;
        while (acc < 0 && k < 10) begin
            @(posedge clk_tb);
            if (s_ready) acc = cyc;
            k++;
        end
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted word=%h", d);
        end
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk_tb);
        #1;
    endtask

    task automatic send_seq(input logic [31:0] w [$], input int first, input int cnt,
                            input bit tog, output int last_acc);
        last_acc = -1;
        for (int i = first; i < first + cnt; i++) begin
            send(w[i], last_acc);
            if (tog && i < first + cnt - 1) idle(1);
        end
    endtask

    logic [31:0] t1 [$];
    logic [31:0] t2 [$];
    int          t_last, t_hdr;

    initial begin
        t1 = '{32'h00010302, 32'h40A00000, 32'h3F000000,
               32'h3F000000, 32'h3F800000, 32'hBF000000, 32'h3F000000, 32'h3F000000, 32'h00000000,
               32'h3F000000, 32'h3F800000, 32'hBF000000, 32'h3F800000};
        t2 = '{32'hAB000202, 32'h3F800000, 32'hBF000000,
               32'h3F000000, 32'h3F000000, 32'h3F800000, 32'h00000000};
        rstn = 1'b0; s_valid = 1'b0; s_data = '0;
        idle(2);
        rstn = 1'b1;
        @(negedge clk_tb);
        chk("rst_ready",   32'(s_ready), 32'd1);
        chk("rst_z_valid", 32'(z_valid), 32'd0);
        chk("rst_n",       32'(zif.n),   32'd0);

        // T1: full load, n=2 ng=3 nc=1
        send_seq(t1, 0, 13, 1'b0, t_last);
        @(negedge clk_tb);
        chk("t1_done",    32'(done),    32'd1);
        chk("t1_z_valid", 32'(z_valid), 32'd1);
        chk("t1_c0",   zif.c[0],    32'h40A00000);
        chk("t1_g02",  zif.g[0][2], 32'hBF000000);
        chk("t1_g12",  zif.g[1][2], 32'h00000000);
        chk("t1_a01",  zif.a[0][1], 32'h3F800000);
        chk("t1_b0",   zif.b[0],    32'h3F800000);
        chk("t1_a10",  zif.a[1][0], 32'h00000000);
        idle(2);
        chk("t1_done_pulse", 32'(done),    32'd0);
        chk("t1_hold",       32'(z_valid), 32'd1);

        // T3: ng=6 rejected, Z unchanged
        send(32'h00010602, t_hdr);
        @(negedge clk_tb);
        chk("t3_err",     32'(err),     32'd1);
        chk("t3_ready",   32'(s_ready), 32'd0);
        chk("t3_z_valid", 32'(z_valid), 32'd1);
        chk("t3_ng",      32'(zif.ng),  32'd3);
        chk("t3_g01",     zif.g[0][1],  32'h3F800000);

        // T2: nc=0 load, upper header bits ignored
        send_seq(t2, 0, 7, 1'b0, t_last);
        @(negedge clk_tb);
        chk("t2_done", 32'(done),   32'd1);
        chk("t2_nc",   32'(zif.nc), 32'd0);
        chk("t2_a00",  zif.a[0][0], 32'h00000000);
        chk("t2_b0",   zif.b[0],    32'h00000000);
        chk("t2_g10",  zif.g[1][0], 32'h3F800000);
        idle(2);

        // T4: T1 with s_valid toggling
        send_seq(t1, 0, 13, 1'b1, t_last);
        @(negedge clk_tb);
        chk("t4_done", 32'(done),   32'd1);
        chk("t4_c1",   zif.c[1],    32'h3F000000);
        chk("t4_a02",  zif.a[0][2], 32'hBF000000);
        idle(2);

        // T5: reset mid-load, then a full load
        send_seq(t1, 0, 6, 1'b0, t_last);
        rstn = 1'b0;
        @(posedge clk_tb);
        #1;
        rstn = 1'b1;
        @(negedge clk_tb);
        chk("t5_n",       32'(zif.n),   32'd0);
        chk("t5_nc",      32'(zif.nc),  32'd0);
        chk("t5_z_valid", 32'(z_valid), 32'd0);
        chk("t5_ready",   32'(s_ready), 32'd1);
        chk("t5_c0",      zif.c[0],     32'h00000000);
        send_seq(t1, 0, 13, 1'b0, t_last);
        @(negedge clk_tb);
        chk("t5_done", 32'(done), 32'd1);
        idle(2);

        // T6: back-to-back loads with s_valid held high
        send_seq(t1, 0, 13, 1'b0, t_last);
        send(t2[0], t_hdr);
        chk("t6_gap", 32'(t_hdr - t_last), 32'd2);
        @(negedge clk_tb);
        chk("t6_z_valid_drop", 32'(z_valid), 32'd0);
        send_seq(t2, 1, 6, 1'b0, t_last);
        @(negedge clk_tb);
        chk("t6_done",    32'(done),    32'd1);
        chk("t6_z_valid", 32'(z_valid), 32'd1);
        chk("t6_nc",      32'(zif.nc),  32'd0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
